// File: rtl/sc_inport_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : sc_inport_debounce_if
//  Purpose  : CPU data-memory read window of the input-port peripheral.
//             Groups the read strobe, register select and read data.
//  Modports : master - CPU side   (drives rd_en/rd_sel, samples rd_data)
//             slave  - peripheral (samples rd_en/rd_sel, drives rd_data)
//  Revision : 1.0  initial release
// ============================================================================
interface sc_inport_debounce_if;
  logic        rd_en;    // read strobe from the I/O decode
  logic [1:0]  rd_sel;   // read register select
  logic [31:0] rd_data;  // read data, combinational from registered state

  modport master (output rd_en, output rd_sel, input rd_data);
  modport slave  (input rd_en, input rd_sel, output rd_data);
endinterface
`default_nettype wire

// File: rtl/sc_inport_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sc_inport_debounce
//  Purpose  : Input side of the single-cycle computer I/O. Synchronizes and
//             debounces 8 slide switches and 4 active-low push keys, drives
//             the debounced switch levels onto in_port0/in_port1 and exposes
//             a memory-mapped read window with sticky, clear-on-read key
//             press flags.
//  Ports    : clock         system clock (posedge)
//             resetn        asynchronous active-low reset
//             sw0, sw1      raw slide switches (async)
//             key           raw push keys, 0 = pressed (async)
//             bus           read window (rd_en, rd_sel, rd_data)
//             in_port0/1    debounced switch levels
//             event_pending OR of all key event flags
//  Revision : 1.0  initial release
// ============================================================================
module sc_inport_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  wire logic                   clock,
  input  wire logic                   resetn,
  input  wire logic [3:0]             sw0,
  input  wire logic [3:0]             sw1,
  input  wire logic [3:0]             key,
  sc_inport_debounce_if.slave         bus,
  output logic      [3:0]             in_port0,
  output logic      [3:0]             in_port1,
  output logic                        event_pending
);

  // Bit layout of all 12 inputs: [3:0] sw0, [7:4] sw1, [11:8] key.
  // Keys rest at 1 (released) so their flops reset high.
  localparam int              NBITS    = 12;
  localparam logic [NBITS-1:0] RST_LVL = 12'hF00;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] raw;
  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [NBITS-1:0] stable;
  logic [NBITS-1:0] accept;    // this bit adopts its synchronized level now
  logic [3:0]       key_fall;  // stable key goes released -> pressed now
  logic [3:0]       evt;
  logic [3:0]       missed;
  logic             rd_clr;

  assign raw = {key, sw1, sw0};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
      logic [CNT_W-1:0] cnt;

      assign accept[i] = (sync2[i] != stable[i]) && (cnt == CNT_LAST);

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          cnt       <= '0;
          stable[i] <= RST_LVL[i];
        end else if (sync2[i] == stable[i]) begin
          // Agreement (or end of a glitch) restarts the qualification window.
          cnt <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  // When accept is set the new stable value is sync2, so a press is
  // "currently released and being accepted as low".
  assign key_fall = accept[11:8] & stable[11:8] & ~sync2[11:8];
  assign rd_clr   = bus.rd_en && (bus.rd_sel == 2'd3);

  // A clearing read consumes the pending events; a press landing on the same
  // edge survives in evt and is not an overflow of an already-read event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evt    <= '0;
      missed <= '0;
    end else if (rd_clr) begin
      evt    <= key_fall;
      missed <= '0;
    end else begin
      evt    <= evt | key_fall;
      missed <= missed | (key_fall & evt);
    end
  end

  always_comb begin
    bus.rd_data = 32'h0;
    case (bus.rd_sel)
      2'd0:    bus.rd_data = {28'h0, stable[3:0]};
      2'd1:    bus.rd_data = {28'h0, stable[7:4]};
      2'd2:    bus.rd_data = {28'h0, ~stable[11:8]};
      default: bus.rd_data = {24'h0, missed, evt};
    endcase
  end

  assign in_port0      = stable[3:0];
  assign in_port1      = stable[7:4];
  assign event_pending = |evt;

endmodule
`default_nettype wire

// File: doc/sc_inport_debounce.md
Name: sc_inport_debounce

Overview:
- Input-side peripheral of the single-cycle computer.
- Synchronizes and debounces the board slide switches and the active-low push keys.
- Drives the debounced switch levels onto the CPU in_port0/in_port1 inputs.
- Exposes a small memory-mapped read window: switch levels, key levels, and sticky key-press event flags that clear on read.
- Complements the seven-segment output path: it is the data-in direction of the same I/O interface.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized cycles required to accept a new level (minimum 2; board builds use 50000).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- sw0  in  4  raw slide switches, group 0, asynchronous.
- sw1  in  4  raw slide switches, group 1, asynchronous.
- key  in  4  raw push keys, active-low (0 = pressed), asynchronous.
- rd_en  in  1  read strobe from the CPU data-memory I/O decode.
- rd_sel  in  2  read register select.
- rd_data  out  32  read data (combinational from registered state).
- in_port0  out  4  debounced sw0 level.
- in_port1  out  4  debounced sw1 level.
- event_pending  out  1  OR of all key event flags.

Behaviour:
- Reset (async, resetn=0):
  - sync flops, switch stable levels: 0.
  - key sync flops, key stable levels: 1 (released).
  - all debounce counters: 0.
  - evt[3:0], missed[3:0]: 0.
  - Resulting outputs: in_port0=0, in_port1=0, event_pending=0.
- Synchronizer: two-flop chain per input bit (12 bits total).
- Debounce, independent per bit:
  - If sync_out == stable: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= sync_out, counter <= 0.
  - Otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes stable; the counter restarts at 0 when the glitch ends.
- Latency: a clean raw edge appears on stable exactly 2+DEBOUNCE_CYCLES posedges later.
- in_port0 = sw0 stable level; in_port1 = sw1 stable level (registered, no combinational path from raw pins).
- Key press event: stable key bit transitions 1->0 sets evt[i] on that posedge.
  - If evt[i] is already 1 at that moment: missed[i] <= 1 as well.
  - Key release (0->1) generates no event.
- Read mux (combinational):
  - sel0 = {28'b0, sw0 stable}
  - sel1 = {28'b0, sw1 stable}
  - sel2 = {28'b0, ~key stable} (1 = pressed)
  - sel3 = {24'b0, missed, evt}
- Read-clear: on a posedge with rd_en=1 and rd_sel=3, evt and missed are cleared.
  - A new event in the same cycle wins: that bit of evt ends at 1; missed for that bit = 0 unless it was set by a coincident overflow.
  - rd_en with rd_sel 0..2 has no side effect.
  - rd_en=0 leaves all state unchanged by the bus.
- event_pending = |evt, registered-state derived; falls the cycle after a clearing read.
- Reset mid-debounce: any partial count is discarded; after release, all bits start from their reset levels. A key held low through reset produces one event 2+DEBOUNCE_CYCLES cycles after resetn rises.

Test Plan:
- Reset with key=4'hF, sw0=4'h0 -> in_port0=0, event_pending=0, rd_sel=3 read returns 32'h0.
- sw0 changes 0->4'hA and is held (DEBOUNCE_CYCLES=16) -> in_port0 stays 0 for 17 posedges and becomes 4'hA at posedge 18; rd_sel=0 returns 32'h0000000A.
- key[1] pulsed low for 10 cycles, then held high -> no change on sel2, evt stays 0. key[1] held low for 30 cycles -> evt=4'h2, event_pending=1, sel2 returns 32'h2 while held.
- Two presses of key[0] with no read between -> sel3 returns 32'h11; a clearing read returns 32'h11 and the next read returns 32'h0.
- Clearing read on the same posedge as a key[2] 1->0 stable edge, with prior evt=4'h1 -> evt ends at 4'h4, missed=0, event_pending stays 1.
- resetn asserted asynchronously mid-count (counter=9 on sw1[3]) -> in_port1 immediately 0; after release, sw1[3] still high -> in_port1[3]=1 after 18 posedges.
